// File: rtl/xor_gate_sequencer.sv
// ---------------------------------------------------------------------------
// xor_gate_sequencer
//
// On-chip exhaustive checker for an N-input XOR gate. A sweep walks the
// gate's input vector from 0 to 2^N-1. Each vector is held for HOLD clock
// cycles. The gate output is sampled on the last hold cycle and compared
// against the reduction-XOR of the vector, and the mismatches are counted.
//
// Parameters
//   N     number of gate inputs (1..8)
//   HOLD  cycles each vector is held (>= 1)
//   CW    width of the error counter
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous, active-high reset
//   start       begin a sweep (accepted only in IDLE, and only without abort)
//   abort       terminate a sweep (RUN); blocks a start in IDLE
//   dut_o       observed gate output
//   dut_i       registered drive vector to the gate inputs
//   busy        high while a sweep is running
//   done        one-cycle pulse when a sweep completes
//   pass        last completed sweep had zero errors; held until next start
//   err_count   mismatches in the current/last sweep, saturating
//   fail_valid  a mismatch has been recorded in this sweep
//   fail_vec    drive vector of the first mismatch in this sweep
//
// Handshake: start and abort are level inputs that are sampled on every
// rising edge. This block does not use a ready/acknowledge signal. A start
// takes effect only on an edge where the FSM is in IDLE and abort is low.
// Any other start is ignored. busy and done report progress. done is
// high for exactly one cycle for each sweep that completes.
//
// Every output is driven straight from a flop. The gate output is only
// used to compute next-state values, so there is no combinational path
// from dut_o to any output.
// ---------------------------------------------------------------------------
module xor_gate_sequencer #(
  parameter int N    = 2,
  parameter int HOLD = 250,
  parameter int CW   = N + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          dut_o,
  output logic [N-1:0]  dut_i,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] err_count,
  output logic          fail_valid,
  output logic [N-1:0]  fail_vec
);

  // -------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------
  // With HOLD == 1, $clog2 returns 0. Keep the hold counter at least 1 bit
  // wide so that it is a legal vector.
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [N-1:0]  VEC_LAST  = {N{1'b1}};
  localparam logic [CW-1:0] ERR_MAX   = {CW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [N-1:0]    dut_i_q, dut_i_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [CW-1:0]   err_count_q, err_count_d;
  logic            fail_valid_q, fail_valid_d;
  logic [N-1:0]    fail_vec_q, fail_vec_d;
  logic            pass_q, pass_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // -------------------------------------------------------------------------
  // Qualifiers shared by the FSM and the datapath
  // -------------------------------------------------------------------------
  logic accept;      // start accepted this edge
  logic in_run;      // running and not being aborted
  logic sample;      // last hold cycle of the current vector
  logic mismatch;    // gate output disagrees with the expected parity
  logic last_vec;    // current vector is the final one of the sweep

  always_comb begin
    accept   = (state_q == S_IDLE) && start && !abort;
    in_run   = (state_q == S_RUN) && !abort;
    sample   = in_run && (hold_cnt_q == HOLD_LAST);
    mismatch = sample && (dut_o != (^dut_i_q));
    last_vec = (dut_i_q == VEC_LAST);
  end

  // -------------------------------------------------------------------------
  // FSM process 1: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // abort has priority over the sample of the same cycle.
        if (abort) begin
          state_d = S_IDLE;
        end else if (sample && last_vec) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Lasts exactly one cycle. start is ignored here.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM process 3: output logic
  // busy and done are decoded from the next state and then registered, so
  // each one is high in the same cycle as the state it reports.
  // -------------------------------------------------------------------------
  always_comb begin
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // -------------------------------------------------------------------------
  // Datapath next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    dut_i_d      = dut_i_q;
    hold_cnt_d   = hold_cnt_q;
    err_count_d  = err_count_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    pass_d       = pass_q;

    case (state_q)
      S_IDLE: begin
        // Clear all sweep results when a start is accepted. A start that
        // abort blocks changes nothing.
        if (accept) begin
          dut_i_d      = '0;
          hold_cnt_d   = '0;
          err_count_d  = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
          pass_d       = 1'b0;
        end
      end

      S_RUN: begin
        if (abort) begin
          // Keep the partial error results so that they can be inspected
          // after an abort.
          dut_i_d    = '0;
          hold_cnt_d = '0;
          pass_d     = 1'b0;
        end else if (sample) begin
          hold_cnt_d = '0;
          if (mismatch) begin
            if (err_count_q != ERR_MAX) begin
              err_count_d = err_count_q + CW'(1);
            end
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              fail_vec_d   = dut_i_q;
            end
          end
          if (last_vec) begin
            // The pass verdict must include this final sample, so it is
            // computed from the updated count.
            pass_d = (err_count_d == '0);
          end else begin
            dut_i_d = dut_i_q + N'(1);
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end

      S_DONE: begin
        dut_i_d    = '0;
        hold_cnt_d = '0;
      end

      default: begin
        dut_i_d    = '0;
        hold_cnt_d = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      dut_i_q      <= '0;
      hold_cnt_q   <= '0;
      err_count_q  <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      pass_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      dut_i_q      <= dut_i_d;
      hold_cnt_q   <= hold_cnt_d;
      err_count_q  <= err_count_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
      pass_q       <= pass_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // -------------------------------------------------------------------------
  // Output assignments
  // -------------------------------------------------------------------------
  assign dut_i      = dut_i_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_count_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

endmodule
